// File: rtl/exwb_stage_buffer.sv
// EX->WB stage buffer: DEPTH-entry in-order queue with flush, precise-exception
// blocking, x0 write masking and a youngest-match forwarding lookup.
module exwb_stage_buffer #(
  parameter int XLEN  = 32,
  parameter int REG_W = 5,
  parameter int EXC_W = 3,
  parameter int DEPTH = 2
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [XLEN-1:0]            in_alu_out,
  input  logic [REG_W-1:0]           in_rd,
  input  logic                       in_reg_write,
  input  logic                       in_mem_to_reg,
  input  logic [EXC_W-1:0]           in_exception_vector,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [XLEN-1:0]            out_alu_out,
  output logic [REG_W-1:0]           out_rd,
  output logic                       out_reg_write,
  output logic                       out_mem_to_reg,
  output logic [EXC_W-1:0]           out_exception_vector,
  input  logic                       flush,
  input  logic [REG_W-1:0]           fwd_rs,
  output logic                       fwd_hit,
  output logic [XLEN-1:0]            fwd_data,
  output logic                       fwd_load_pending,
  output logic [$clog2(DEPTH+1)-1:0] count
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(DEPTH+1);

  logic [XLEN-1:0]  alu_q [DEPTH];
  logic [XLEN-1:0]  alu_d [DEPTH];
  logic [REG_W-1:0] rd_q  [DEPTH];
  logic [REG_W-1:0] rd_d  [DEPTH];
  logic [EXC_W-1:0] exc_q [DEPTH];
  logic [EXC_W-1:0] exc_d [DEPTH];
  logic [DEPTH-1:0] rw_q, rw_d;
  logic [DEPTH-1:0] m2r_q, m2r_d;

  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             exc_block_q, exc_block_d;

  logic push, pop;

  assign in_ready  = (count_q != CNT_W'(DEPTH)) && !exc_block_q;
  assign out_valid = (count_q != '0);
  assign push      = in_valid && in_ready;
  assign pop       = out_valid && out_ready;
  assign count     = count_q;

  // flush overrides any same-cycle push or pop
  always_comb begin
    alu_d       = alu_q;
    rd_d        = rd_q;
    exc_d       = exc_q;
    rw_d        = rw_q;
    m2r_d       = m2r_q;
    rd_ptr_d    = rd_ptr_q;
    wr_ptr_d    = wr_ptr_q;
    count_d     = count_q;
    exc_block_d = exc_block_q;
    if (flush) begin
      rd_ptr_d    = '0;
      wr_ptr_d    = '0;
      count_d     = '0;
      exc_block_d = 1'b0;
    end else begin
      if (pop) begin
        rd_ptr_d = rd_ptr_q + PTR_W'(1);
        if (exc_q[rd_ptr_q] != '0) exc_block_d = 1'b0;
      end
      if (push) begin
        alu_d[wr_ptr_q] = in_alu_out;
        rd_d[wr_ptr_q]  = in_rd;
        exc_d[wr_ptr_q] = in_exception_vector;
        rw_d[wr_ptr_q]  = in_reg_write && (in_rd != '0) && (in_exception_vector == '0);
        m2r_d[wr_ptr_q] = in_mem_to_reg;
        wr_ptr_d        = wr_ptr_q + PTR_W'(1);
        if (in_exception_vector != '0) exc_block_d = 1'b1;
      end
      if (push && !pop) begin
        count_d = count_q + CNT_W'(1);
      end else if (pop && !push) begin
        count_d = count_q - CNT_W'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      rd_ptr_q    <= '0;
      wr_ptr_q    <= '0;
      count_q     <= '0;
      exc_block_q <= 1'b0;
      rw_q        <= '0;
      m2r_q       <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        alu_q[i] <= '0;
        rd_q[i]  <= '0;
        exc_q[i] <= '0;
      end
    end else begin
      rd_ptr_q    <= rd_ptr_d;
      wr_ptr_q    <= wr_ptr_d;
      count_q     <= count_d;
      exc_block_q <= exc_block_d;
      rw_q        <= rw_d;
      m2r_q       <= m2r_d;
      alu_q       <= alu_d;
      rd_q        <= rd_d;
      exc_q       <= exc_d;
    end
  end

  always_comb begin
    out_alu_out          = '0;
    out_rd               = '0;
    out_reg_write        = 1'b0;
    out_mem_to_reg       = 1'b0;
    out_exception_vector = '0;
    if (out_valid) begin
      out_alu_out          = alu_q[rd_ptr_q];
      out_rd               = rd_q[rd_ptr_q];
      out_reg_write        = rw_q[rd_ptr_q];
      out_mem_to_reg       = m2r_q[rd_ptr_q];
      out_exception_vector = exc_q[rd_ptr_q];
    end
  end

  // Walk oldest to youngest so the last match found is the youngest one.
  logic            fwd_found;
  logic            fwd_found_m2r;
  logic [XLEN-1:0] fwd_found_alu;

  always_comb begin
    fwd_found     = 1'b0;
    fwd_found_m2r = 1'b0;
    fwd_found_alu = '0;
    for (int k = 0; k < DEPTH; k++) begin
      if ((CNT_W'(k) < count_q) &&
          rw_q[rd_ptr_q + PTR_W'(k)] &&
          (rd_q[rd_ptr_q + PTR_W'(k)] == fwd_rs)) begin
        fwd_found     = 1'b1;
        fwd_found_m2r = m2r_q[rd_ptr_q + PTR_W'(k)];
        fwd_found_alu = alu_q[rd_ptr_q + PTR_W'(k)];
      end
    end
  end

  always_comb begin
    fwd_hit          = 1'b0;
    fwd_load_pending = 1'b0;
    fwd_data         = '0;
    if (fwd_found && (fwd_rs != '0)) begin
      if (fwd_found_m2r) begin
        fwd_load_pending = 1'b1;
      end else begin
        fwd_hit  = 1'b1;
        fwd_data = fwd_found_alu;
      end
    end
  end

endmodule

// File: tb/tb_exwb_stage_buffer.sv
// Scoreboard bench for exwb_stage_buffer: stimulus queues expected entries,
// a negedge monitor checks every entry WB consumes.
module tb_exwb_stage_buffer;

  logic        clk;
  logic        reset;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_alu_out;
  logic [4:0]  in_rd;
  logic        in_reg_write;
  logic        in_mem_to_reg;
  logic [2:0]  in_exception_vector;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_alu_out;
  logic [4:0]  out_rd;
  logic        out_reg_write;
  logic        out_mem_to_reg;
  logic [2:0]  out_exception_vector;
  logic        flush;
  logic [4:0]  fwd_rs;
  logic        fwd_hit;
  logic [31:0] fwd_data;
  logic        fwd_load_pending;
  logic [1:0]  count;

  typedef struct {
    logic [31:0] alu;
    logic [4:0]  rd;
    logic        rw;
    logic        m2r;
    logic [2:0]  exc;
  } exp_t;

  exp_t sb_q[$];
  int   pass_cnt = 0;
  int   total_cnt = 0;

  exwb_stage_buffer #(.XLEN(32), .REG_W(5), .EXC_W(3), .DEPTH(2)) dut (
    .clk                  (clk),
    .reset                (reset),
    .in_valid             (in_valid),
    .in_ready             (in_ready),
    .in_alu_out           (in_alu_out),
    .in_rd                (in_rd),
    .in_reg_write         (in_reg_write),
    .in_mem_to_reg        (in_mem_to_reg),
    .in_exception_vector  (in_exception_vector),
    .out_valid            (out_valid),
    .out_ready            (out_ready),
    .out_alu_out          (out_alu_out),
    .out_rd               (out_rd),
    .out_reg_write        (out_reg_write),
    .out_mem_to_reg       (out_mem_to_reg),
    .out_exception_vector (out_exception_vector),
    .flush                (flush),
    .fwd_rs               (fwd_rs),
    .fwd_hit              (fwd_hit),
    .fwd_data             (fwd_data),
    .fwd_load_pending     (fwd_load_pending),
    .count                (count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    total_cnt++;
    if (act === exp) pass_cnt++;
    else $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
  endtask

  // Drive one accepted push for a cycle and queue the entry WB should later see.
  task automatic applyStimulus(input logic [31:0] alu, input logic [4:0] rd,
                               input logic rw, input logic m2r, input logic [2:0] exc);
    exp_t e;
    in_valid            = 1'b1;
    in_alu_out          = alu;
    in_rd               = rd;
    in_reg_write        = rw;
    in_mem_to_reg       = m2r;
    in_exception_vector = exc;
    @(negedge clk);
    checkOutput("push_ready", 32'(in_ready), 32'd1);
    e.alu = alu;
    e.rd  = rd;
    e.rw  = rw && (rd != 5'd0) && (exc == 3'd0);
    e.m2r = m2r;
    e.exc = exc;
    sb_q.push_back(e);
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  task automatic popOne();
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
  endtask

  always @(negedge clk) begin
    if (!reset && out_valid && out_ready) begin
      if (sb_q.size() == 0) begin
        checkOutput("unexpected_pop", 32'(out_alu_out), 32'hFFFF_FFFF);
      end else begin
        exp_t e;
        e = sb_q.pop_front();
        checkOutput("mon_alu", out_alu_out, e.alu);
        checkOutput("mon_rd", 32'(out_rd), 32'(e.rd));
        checkOutput("mon_rw", 32'(out_reg_write), 32'(e.rw));
        checkOutput("mon_m2r", 32'(out_mem_to_reg), 32'(e.m2r));
        checkOutput("mon_exc", 32'(out_exception_vector), 32'(e.exc));
      end
    end
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    reset = 1'b1;
    in_valid = 1'b0; in_alu_out = '0; in_rd = '0; in_reg_write = 1'b0;
    in_mem_to_reg = 1'b0; in_exception_vector = '0;
    out_ready = 1'b0; flush = 1'b0; fwd_rs = '0;
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;

    checkOutput("rst_count", 32'(count), 32'd0);
    checkOutput("rst_in_ready", 32'(in_ready), 32'd1);
    checkOutput("rst_out_valid", 32'(out_valid), 32'd0);
    checkOutput("rst_out_alu", out_alu_out, 32'd0);
    checkOutput("rst_fwd_hit", 32'(fwd_hit), 32'd0);

    // single push shows up next cycle
    applyStimulus(32'h1234, 5'd5, 1'b1, 1'b0, 3'd0);
    checkOutput("t1_out_valid", 32'(out_valid), 32'd1);
    checkOutput("t1_out_alu", out_alu_out, 32'h1234);
    checkOutput("t1_count", 32'(count), 32'd1);
    checkOutput("t1_in_ready", 32'(in_ready), 32'd1);
    popOne();
    checkOutput("t1_count_drain", 32'(count), 32'd0);

    // fill to DEPTH, then pop one
    applyStimulus(32'h11, 5'd1, 1'b1, 1'b0, 3'd0);
    applyStimulus(32'h22, 5'd2, 1'b1, 1'b0, 3'd0);
    checkOutput("t2_count_full", 32'(count), 32'd2);
    checkOutput("t2_in_ready_full", 32'(in_ready), 32'd0);
    popOne();
    checkOutput("t2_count", 32'(count), 32'd1);
    checkOutput("t2_head_alu", out_alu_out, 32'h22);
    checkOutput("t2_in_ready", 32'(in_ready), 32'd1);
    popOne();

    // x0 masking and exception blocking
    applyStimulus(32'h33, 5'd0, 1'b1, 1'b0, 3'd0);
    checkOutput("t3_x0_rw", 32'(out_reg_write), 32'd0);
    popOne();
    applyStimulus(32'h44, 5'd7, 1'b1, 1'b0, 3'b010);
    checkOutput("t3_exc_rw", 32'(out_reg_write), 32'd0);
    checkOutput("t3_exc_vec", 32'(out_exception_vector), 32'd2);
    checkOutput("t3_exc_block", 32'(in_ready), 32'd0);
    in_valid = 1'b1; in_alu_out = 32'hDEAD; in_rd = 5'd8; in_reg_write = 1'b1;
    in_exception_vector = 3'd0;
    @(posedge clk); #1;
    in_valid = 1'b0;
    checkOutput("t3_blocked_count", 32'(count), 32'd1);
    checkOutput("t3_still_blocked", 32'(in_ready), 32'd0);
    popOne();
    checkOutput("t3_unblocked", 32'(in_ready), 32'd1);
    checkOutput("t3_empty", 32'(out_valid), 32'd0);

    // forwarding: youngest match wins, loads stall
    applyStimulus(32'hA, 5'd9, 1'b1, 1'b0, 3'd0);
    applyStimulus(32'hB, 5'd9, 1'b1, 1'b0, 3'd0);
    fwd_rs = 5'd9; #1;
    checkOutput("t4_fwd_hit", 32'(fwd_hit), 32'd1);
    checkOutput("t4_fwd_data", fwd_data, 32'hB);
    checkOutput("t4_fwd_pend", 32'(fwd_load_pending), 32'd0);
    fwd_rs = 5'd0; #1;
    checkOutput("t4_fwd_x0", 32'(fwd_hit), 32'd0);
    popOne();
    applyStimulus(32'hC, 5'd9, 1'b1, 1'b1, 3'd0);
    fwd_rs = 5'd9; #1;
    checkOutput("t4_load_hit", 32'(fwd_hit), 32'd0);
    checkOutput("t4_load_pend", 32'(fwd_load_pending), 32'd1);
    checkOutput("t4_load_data", fwd_data, 32'd0);
    fwd_rs = 5'd3; #1;
    checkOutput("t4_nomatch_hit", 32'(fwd_hit), 32'd0);
    checkOutput("t4_nomatch_pend", 32'(fwd_load_pending), 32'd0);
    popOne();
    popOne();
    checkOutput("t4_count", 32'(count), 32'd0);

    // flush with two entries and a same-cycle input
    applyStimulus(32'h55, 5'd5, 1'b1, 1'b0, 3'd0);
    applyStimulus(32'h66, 5'd6, 1'b1, 1'b0, 3'd0);
    flush = 1'b1; in_valid = 1'b1; in_alu_out = 32'h77; in_rd = 5'd7;
    @(posedge clk); #1;
    flush = 1'b0; in_valid = 1'b0;
    sb_q.delete();
    checkOutput("t5_count", 32'(count), 32'd0);
    checkOutput("t5_out_valid", 32'(out_valid), 32'd0);
    checkOutput("t5_out_alu", out_alu_out, 32'd0);
    checkOutput("t5_out_rd", 32'(out_rd), 32'd0);
    checkOutput("t5_in_ready", 32'(in_ready), 32'd1);

    // flush with one entry, so the input would have been accepted without flush
    applyStimulus(32'h88, 5'd8, 1'b1, 1'b0, 3'd0);
    flush = 1'b1; in_valid = 1'b1; in_alu_out = 32'h99; in_rd = 5'd9;
    @(posedge clk); #1;
    flush = 1'b0; in_valid = 1'b0;
    sb_q.delete();
    checkOutput("t5b_count", 32'(count), 32'd0);
    checkOutput("t5b_out_valid", 32'(out_valid), 32'd0);

    // back-to-back streaming through wrapping pointers
    out_ready = 1'b1;
    for (int i = 0; i < 10; i++) begin
      applyStimulus(32'h100 + 32'(i), 5'(i + 1), 1'b1, 1'b0, 3'd0);
      checkOutput("t6_count", 32'(count), 32'd1);
    end
    @(posedge clk); #1;
    out_ready = 1'b0;
    checkOutput("t6_count_end", 32'(count), 32'd0);
    checkOutput("t6_sb_empty", 32'(sb_q.size()), 32'd0);

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
